// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Entries pair a fetch PC with its instruction word.
package fetch_pkg;

  localparam int FETCH_W     = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int CNT_W       = $clog2(FETCH_DEPTH) + 1;

  localparam logic [FETCH_W-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [FETCH_W-1:0] DEFAULT_PC_INC   = 32'd4;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] inst;
  } fetch_entry_t;

  // RUN: every response is kept. DRAIN: responses from flushed fetches are still due.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response, decode queue.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// a valid source holds its payload stable until that edge (a redirect may withdraw
// imem_req_valid); imem_rsp_valid has no ready and is accepted unconditionally.
interface fetch_if #(
  parameter int W = 32
);
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst_data;
  logic [W-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_queue.sv
// Registered FIFO of fetch entries with synchronous flush.
// Push and pop together while empty passes the entry straight through without storing it.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pass;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pass = push && pop && empty;
  assign do_push = push && !do_pass;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests, response queue, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           W        = FETCH_W,
  parameter int           DEPTH    = FETCH_DEPTH,
  parameter logic [W-1:0] PC_INC   = DEFAULT_PC_INC,
  parameter logic [W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_if.master      bus,
  output fetch_state_t dbg_state
);

  localparam int         CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  logic          q_full, q_empty, q_push, q_pop;
  fetch_entry_t  q_head, rsp_entry;
  logic          req_valid, req_fire, rsp_keep, bypass, inst_valid_w;

  // Dropped-but-pending responses still hold a credit, so DRAIN can keep fetching.
  assign inflight  = {1'b0, occ} + {1'b0, out_q};
  assign req_valid = reset_n && !bus.redirect_valid && (inflight < DEPTH_C);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_keep  = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign rsp_entry = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid_w       = !q_empty || bypass;
  assign q_push             = rsp_keep;
  assign q_pop              = inst_valid_w && bus.inst_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = inst_valid_w;
  assign bus.inst_data      = bypass ? bus.imem_rsp_data : q_head.inst;
  assign bus.inst_pc        = bypass ? rsp_pc_q : q_head.pc;
  assign dbg_state          = state_q;

  inst_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (bus.redirect_valid),
    .push       (q_push),
    .push_entry (rsp_entry),
    .pop        (q_pop),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (occ)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      // Everything still owed by memory after this edge belongs to the old stream.
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      drop_d     = out_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (bus.imem_rsp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + PC_INC;
      end
    end
    state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(q_push && q_full && !q_pop && !bus.redirect_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 1-cycle memory model with hold-off, in-order delivery scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  fetch_state_t dbg_state;
  bit           mem_en;

  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] iss_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  fetch_if #(.W(32)) bus ();

  fetch_unit #(.W(32), .DEPTH(4), .PC_INC(32'd4), .RESET_PC(32'd0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then present the memory response after the edge.
  task automatic tick(output bit got);
    logic [31:0] e, ed;
    @(negedge clk);
    got = 1'b0;
    if (bus.inst_valid && bus.inst_ready) begin
      got = 1'b1;
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_delivery obs_pc=%h exp=none", bus.inst_pc);
      end
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ed = ~e;
        chk("deliver_pc", bus.inst_pc, e);
        chk("deliver_data", bus.inst_data, ed);
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend_q.push_back(bus.imem_req_addr);
      iss_q.push_back(bus.imem_req_addr);
    end
    @(posedge clk);
    #1;
    if (mem_en && pend_q.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ~pend_q.pop_front();
    end else begin
      bus.imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    reset_n            = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    pend_q.delete();
    iss_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int cyc = 0;
    bit got;
    while (exp_q.size() > 0 && cyc < budget) begin
      tick(got);
      cyc++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int first, cyc;
    bit got;
    logic [31:0] wrap_pc[4];
    wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    reset_n            = 1'b0;
    mem_en             = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    #2;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));

    // Streaming with always-ready memory and decode.
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    reset_dut();
    #1;
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_first_addr", bus.imem_req_addr, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    tick(got);
    #1;
`ifdef FETCH_BYPASS_EN
    chk("t1_bypass_valid", 32'(bus.inst_valid), 32'd1);
    chk("t1_bypass_pc", bus.inst_pc, 32'h0);
`else
    chk("t1_latency_valid", 32'(bus.inst_valid), 32'd0);
`endif
    chk("t1_second_addr", bus.imem_req_addr, 32'h4);
    first = -1;
    cyc   = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      tick(got);
      cyc++;
      if (got && first < 0) first = cyc;
    end
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_no_gaps", 32'(cyc - first + 1), 32'd8);
    exp_q.delete();

    // Decode stalled: credit stops at four requests.
    bus.inst_ready = 1'b0;
    reset_dut();
    repeat (8) tick(got);
    #1;
    chk("t2_issued", 32'(iss_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_issue_addr", iss_q[i], 32'(i * 4));
    chk("t2_req_valid_off", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("t2_head_pc", bus.inst_pc, 32'h0);
    chk("t2_head_data", bus.inst_data, 32'hFFFF_FFFF);
    chk("t2_next_addr", bus.imem_req_addr, 32'h10);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    run_until_empty("t2", 30);
    chk("t2_resume_addr", iss_q[4], 32'h10);

    // Redirect with three requests outstanding.
    mem_en = 1'b0;
    reset_dut();
    repeat (3) tick(got);
    #1;
    chk("t3_issued", 32'(iss_q.size()), 32'd3);
    chk("t3_pending_addr", bus.imem_req_addr, 32'hC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("t3_no_req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
    tick(got);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_req_addr", bus.imem_req_addr, 32'h100);
    chk("t3_queue_empty", 32'(bus.inst_valid), 32'd0);
    chk("t3_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    mem_en = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    run_until_empty("t3", 40);
    chk("t3_state_run", 32'(dbg_state), 32'(ST_RUN));

    // Redirect colliding with a response and a pending request.
    bus.inst_ready = 1'b0;
    reset_dut();
    tick(got);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("t4_req_suppressed", 32'(bus.imem_req_valid), 32'd0);
    chk("t4_no_bypass", 32'(bus.inst_valid), 32'd0);
    tick(got);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_issued", 32'(iss_q.size()), 32'd1);
    chk("t4_req_addr", bus.imem_req_addr, 32'h200);
    chk("t4_rsp_dropped", 32'(bus.inst_valid), 32'd0);
    chk("t4_state_run", 32'(dbg_state), 32'(ST_RUN));
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    run_until_empty("t4", 30);

    // PC wrap through the top of the address space.
    reset_dut();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick(got);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(wrap_pc[i]);
    run_until_empty("t5", 30);
    chk("t5_issued_enough", 32'(iss_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("t5_issue_addr", iss_q[i], wrap_pc[i]);

    // Reset mid-operation: two queued, two outstanding.
    bus.inst_ready = 1'b0;
    reset_dut();
    tick(got);
    tick(got);
    mem_en = 1'b0;
    tick(got);
    tick(got);
    chk("t6_issued", 32'(iss_q.size()), 32'd4);
    chk("t6_inst_valid", 32'(bus.inst_valid), 32'd1);
    reset_n            = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    pend_q.delete();
    #1;
    chk("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_rst_addr", bus.imem_req_addr, 32'h0);
    chk("t6_rst_inst_data", bus.inst_data, 32'h0);
    chk("t6_rst_inst_pc", bus.inst_pc, 32'h0);
    chk("t6_rst_state", 32'(dbg_state), 32'(ST_RUN));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    iss_q.delete();
    mem_en         = 1'b1;
    bus.inst_ready = 1'b1;
    #1;
    chk("t6_restart_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t6_restart_addr", bus.imem_req_addr, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    run_until_empty("t6", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
